regfile_dbg_master: RTL and testbench

- Debug initiator that drives the register file's debug port (ra_db/rd_db, wa_db/wd_db/we_db) from a host byte stream.
- Receives command bytes and write data on an 8-bit valid/ready input stream. Returns read data and acknowledgements on an 8-bit valid/ready output stream.
- Sits between the host link (UART/JTAG bridge) and the core's regfile. Only one debug transaction is in flight at a time.

---
 rtl/regfile_dbg_master.sv | 255 +++++++++++++++++++++++++
 tb/tb_regfile_dbg_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_master.sv
// -----------------------------------------------------------------------------
// regfile_dbg_master
//
// Debug initiator for the core register file. A host byte stream (UART/JTAG
// bridge) sends command bytes and write data on an 8-bit valid/ready input.
// The block turns them into accesses on the regfile debug port. It returns
// read data, write acknowledgements and error bytes on an 8-bit valid/ready
// output. Only one debug transaction is in flight at any time.
//
// Command byte: [7:5] opcode, [4:0] register address.
//   3'b000 READ  : returns NB bytes of the register, LSB first
//   3'b100 WRITE : takes NB data bytes (LSB first), writes, returns ACK_BYTE
//   3'b011 DUMP  : only when REGFILE_DBG_DUMP_EN is defined; streams all 32
//                  registers (x0 first, each LSB first). Without the macro
//                  this opcode is treated as unsupported.
//   others       : returns ERR_BYTE
//
// Optional feature macro: REGFILE_DBG_DUMP_EN
//
// Ports:
//   clk       in   core clock
//   reset     in   asynchronous, active-high reset
//   rx_data   in   [7:0]      host command/data byte
//   rx_valid  in              rx_data valid
//   rx_ready  out             byte accepted this cycle when rx_valid is also high
//   tx_data   out  [7:0]      response byte to host
//   tx_valid  out             tx_data valid
//   tx_ready  in              host accepts tx byte this cycle
//   ra_db     out  [4:0]      regfile debug read address
//   rd_db     in   [XLEN-1:0] regfile debug read data (combinational from ra_db)
//   wa_db     out  [4:0]      regfile debug write address
//   wd_db     out  [XLEN-1:0] regfile debug write data
//   we_db     out             regfile debug write enable (one-cycle pulse)
//   busy      out             high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module regfile_dbg_master #(
    parameter int         XLEN     = 64,
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [4:0]      ra_db,
    input  logic [XLEN-1:0] rd_db,
    output logic [4:0]      wa_db,
    output logic [XLEN-1:0] wd_db,
    output logic            we_db,
    output logic            busy
);

    localparam int NB = XLEN / 8;
    // Counter must be at least one bit wide even for a single-byte register.
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b100;
`ifdef REGFILE_DBG_DUMP_EN
    localparam logic [2:0] OP_DUMP  = 3'b011;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        TX_DATA,
        WR_DATA,
        WR_COMMIT,
        TX_ACK,
        TX_ERR
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [CW-1:0]   byte_cnt_reg;
    logic [XLEN-1:0] wd_shift_reg;
    logic [XLEN-1:0] wd_merged;
    logic [XLEN-1:0] tx_shift_reg;

    logic       rx_fire;
    logic       tx_fire;
    logic       last_byte;
    logic [2:0] opcode;

`ifdef REGFILE_DBG_DUMP_EN
    logic dump_reg;
    // The dump ends after register 31 has been streamed out; ra_db doubles
    // as the register counter.
    logic dump_more;
    assign dump_more = dump_reg && (ra_db != 5'd31);
`endif

    // rx_ready is gated by reset so that every output is 0 while reset is
    // held, and the block becomes ready as soon as reset is released.
    assign rx_ready  = !reset && ((state_reg == IDLE) || (state_reg == WR_DATA));
    assign tx_valid  = (state_reg == TX_DATA) || (state_reg == TX_ACK) || (state_reg == TX_ERR);
    assign tx_data   = (state_reg == TX_DATA) ? tx_shift_reg[7:0] :
                       (state_reg == TX_ACK)  ? ACK_BYTE :
                       (state_reg == TX_ERR)  ? ERR_BYTE : 8'h00;
    assign busy      = (state_reg != IDLE);

    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign last_byte = (byte_cnt_reg == LAST_BYTE);
    assign opcode    = rx_data[7:5];

    // Write word with the incoming byte dropped into its lane, so the final
    // byte can be committed to wd_db in the same cycle it is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign wd_merged[gi*8 +: 8] = (byte_cnt_reg == CW'(gi)) ? rx_data
                                                                     : wd_shift_reg[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and the write strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        we_db      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_fire) begin
                    case (opcode)
                        OP_READ:  state_next = RD_ISSUE;
                        OP_WRITE: state_next = WR_DATA;
`ifdef REGFILE_DBG_DUMP_EN
                        OP_DUMP:  state_next = RD_ISSUE;
`endif
                        default:  state_next = TX_ERR;
                    endcase
                end
            end
            RD_ISSUE:   state_next = RD_CAPTURE;
            RD_CAPTURE: state_next = TX_DATA;
            TX_DATA: begin
                if (tx_fire && last_byte) begin
`ifdef REGFILE_DBG_DUMP_EN
                    state_next = dump_more ? RD_ISSUE : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
            WR_DATA: begin
                if (rx_fire && last_byte) begin
                    state_next = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                we_db      = 1'b1;
                state_next = TX_ACK;
            end
            TX_ACK: begin
                if (tx_fire) begin
                    state_next = IDLE;
                end
            end
            TX_ERR: begin
                if (tx_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: addresses, byte counter, write assembly, tx shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_reg <= '0;
            wd_shift_reg <= '0;
            tx_shift_reg <= '0;
            ra_db        <= '0;
            wa_db        <= '0;
            wd_db        <= '0;
`ifdef REGFILE_DBG_DUMP_EN
            dump_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rx_fire) begin
                        byte_cnt_reg <= '0;
`ifdef REGFILE_DBG_DUMP_EN
                        dump_reg     <= (opcode == OP_DUMP);
                        if (opcode == OP_DUMP) begin
                            ra_db <= 5'd0;
                        end
`endif
                        if (opcode == OP_READ) begin
                            ra_db <= rx_data[4:0];
                        end
                        if (opcode == OP_WRITE) begin
                            wa_db <= rx_data[4:0];
                        end
                    end
                end
                RD_CAPTURE: begin
                    tx_shift_reg <= rd_db;
                    byte_cnt_reg <= '0;
                end
                TX_DATA: begin
                    if (tx_fire) begin
                        tx_shift_reg <= tx_shift_reg >> 8;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
`ifdef REGFILE_DBG_DUMP_EN
                        if (last_byte) begin
                            if (dump_more) begin
                                ra_db <= ra_db + 5'd1;
                            end else begin
                                dump_reg <= 1'b0;
                            end
                        end
`endif
                    end
                end
                WR_DATA: begin
                    if (rx_fire) begin
                        wd_shift_reg <= wd_merged;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        if (last_byte) begin
                            wd_db <= wd_merged;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_master.sv
module tb_regfile_dbg_master;

    localparam int XLEN = 64;
    localparam int NB   = XLEN / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [4:0]      ra_db;
    logic [XLEN-1:0] rd_db;
    logic [4:0]      wa_db;
    logic [XLEN-1:0] wd_db;
    logic            we_db;
    logic            busy;

    regfile_dbg_master #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ra_db    (ra_db),
        .rd_db    (rd_db),
        .wa_db    (wa_db),
        .wd_db    (wd_db),
        .we_db    (we_db),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Stand-in register file: combinational read, clocked write.
    logic [XLEN-1:0] rf [32];
    logic            rf_init;

    function automatic logic [XLEN-1:0] init_val(input int i);
        if (i == 0) return '0;
        return 64'(i) * 64'h0123_4567_89AB_CDEF + 64'h1;
    endfunction

    assign rd_db = rf[ra_db];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (we_db) begin
            rf[wa_db] <= wd_db;
        end
    end

    // Cycle counter and write-strobe monitor.
    int              cyc = 0;
    int              we_cnt = 0;
    int              we_cyc = 0;
    logic [4:0]      we_wa;
    logic [XLEN-1:0] we_wd;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_db) begin
            we_cnt <= we_cnt + 1;
            we_cyc <= cyc;
            we_wa  <= wa_db;
            we_wd  <= wd_db;
        end
    end

    // Scoreboard and counters
    logic [7:0]      exp_q [$];
    logic [XLEN-1:0] exp_rf [32];
    int              total = 0;
    int              bad = 0;
    int              last_acc_cyc = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rx_accept_timeout", XLEN'(t < 100), XLEN'(1));
        last_acc_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        $display("rx byte %02h accepted in cycle %0d", b, last_acc_cyc);
    endtask

    task automatic push_word(input logic [XLEN-1:0] w);
        for (int i = 0; i < NB; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    // Waits for a tx byte, optionally holds it off for 'stall' cycles, then
    // takes it and compares against the head of the scoreboard.
    task automatic recv_byte(input int stall);
        int         t = 0;
        logic [7:0] e;
        while (!tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_valid_timeout", XLEN'(t < 200), XLEN'(1));
        check("tx_queue_nonempty", XLEN'(exp_q.size() > 0), XLEN'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        for (int s = 0; s < stall; s++) begin
            check("tx_hold_data", XLEN'(tx_data), XLEN'(e));
            check("tx_hold_valid", XLEN'(tx_valid), XLEN'(1));
            @(negedge clk);
        end
        check("tx_byte", XLEN'(tx_data), XLEN'(e));
        $display("tx byte %02h (expected %02h) cycle %0d", tx_data, e, cyc);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input int stall_idx);
        push_word(exp_rf[a]);
        send_byte({3'b000, a});
        check("rd_issue_ra", XLEN'(ra_db), XLEN'(a));
        check("rd_issue_busy", XLEN'(busy), XLEN'(1));
        @(negedge clk);
        check("rd_capture_ra", XLEN'(ra_db), XLEN'(a));
        check("rd_capture_txv", XLEN'(tx_valid), XLEN'(0));
        for (int i = 0; i < NB; i++) recv_byte((i == stall_idx) ? 4 : 0);
        check("rd_done_busy", XLEN'(busy), XLEN'(0));
        check("rd_done_rx_ready", XLEN'(rx_ready), XLEN'(1));
        $display("read x%0d done", a);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [XLEN-1:0] w);
        int prev = we_cnt;
        send_byte({3'b100, a});
        for (int i = 0; i < NB; i++) send_byte(w[8*i +: 8]);
        check("wr_commit_we", XLEN'(we_db), XLEN'(1));
        @(negedge clk);
        check("wr_we_one_cycle", XLEN'(we_db), XLEN'(0));
        check("wr_we_count", XLEN'(we_cnt), XLEN'(prev + 1));
        check("wr_we_addr", XLEN'(we_wa), XLEN'(a));
        check("wr_we_data", we_wd, w);
        check("wr_we_cycle", XLEN'(we_cyc), XLEN'(last_acc_cyc + 1));
        exp_q.push_back(8'hA5);
        recv_byte(0);
        check("wr_done_busy", XLEN'(busy), XLEN'(0));
        exp_rf[a] = w;
        $display("write x%0d = %016h done", a, w);
    endtask

    initial begin
        int prev;
        reset    = 1'b1;
        rf_init  = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) exp_rf[i] = init_val(i);

        // Reset state
        #1;
        check("rst_rx_ready", XLEN'(rx_ready), XLEN'(0));
        check("rst_tx_valid", XLEN'(tx_valid), XLEN'(0));
        check("rst_busy", XLEN'(busy), XLEN'(0));
        check("rst_we", XLEN'(we_db), XLEN'(0));
        repeat (2) @(negedge clk);
        rf_init = 1'b0;
        reset   = 1'b0;
        #1;
        check("post_rst_rx_ready", XLEN'(rx_ready), XLEN'(1));
        check("post_rst_busy", XLEN'(busy), XLEN'(0));
        @(negedge clk);

        // Plain read and a write to get non-zero address/data registers
        do_read(5'd3, -1);
        do_write(5'd9, 64'hCAFE_F00D_1234_5678);

        // Reset in the middle of a WRITE data phase
        prev = we_cnt;
        send_byte(8'h85);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rx_ready", XLEN'(rx_ready), XLEN'(0));
        check("mid_rst_tx_valid", XLEN'(tx_valid), XLEN'(0));
        check("mid_rst_tx_data", XLEN'(tx_data), XLEN'(0));
        check("mid_rst_busy", XLEN'(busy), XLEN'(0));
        check("mid_rst_we", XLEN'(we_db), XLEN'(0));
        check("mid_rst_ra", XLEN'(ra_db), XLEN'(0));
        check("mid_rst_wa", XLEN'(wa_db), XLEN'(0));
        check("mid_rst_wd", wd_db, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_no_we", XLEN'(we_cnt), XLEN'(prev));
        $display("mid-stream reset done");
        do_read(5'd5, -1);

        // Full write then read back with backpressure on the third byte
        do_write(5'd5, 64'h8877_6655_4433_2211);
        do_read(5'd5, 2);

        // Unsupported opcode
        prev = we_cnt;
        exp_q.push_back(8'hEE);
        send_byte(8'h40);
        check("err_busy", XLEN'(busy), XLEN'(1));
        recv_byte(0);
        check("err_busy_drop", XLEN'(busy), XLEN'(0));
        check("err_no_we", XLEN'(we_cnt), XLEN'(prev));
        $display("bad opcode 40 done");

`ifdef REGFILE_DBG_DUMP_EN
        do_write(5'd1, {XLEN{1'b1}});
        for (int r = 0; r < 32; r++) push_word(exp_rf[r]);
        send_byte(8'h60);
        for (int i = 0; i < 32 * NB; i++) recv_byte(0);
        check("dump_busy_drop", XLEN'(busy), XLEN'(0));
        $display("dump done");
`else
        prev = we_cnt;
        exp_q.push_back(8'hEE);
        send_byte(8'h60);
        recv_byte(0);
        check("nodump_busy_drop", XLEN'(busy), XLEN'(0));
        check("nodump_no_we", XLEN'(we_cnt), XLEN'(prev));
        $display("opcode 60 without dump done");
`endif

        // Address 0 is passed straight through
        do_write(5'd0, 64'hDEAD_BEEF_0000_1234);
        do_read(5'd0, -1);

        check("scoreboard_empty", XLEN'(exp_q.size()), XLEN'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
